mem_responder: RTL and testbench

Memory-side responder for the micro-processor address bus. It accepts one request at a time, carrying an 8-bit address, a read/write flag and a fetch tag. It services the request against an internal 256x8 register memory after a programmable number of wait states, then returns a one-cycle acknowledge. On acknowledged instruction fetches it also loads the instruction register.

---
 rtl/mem_responder.sv | 123 ++++++++++++
 tb/tb_mem_responder.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: samples a bus request in IDLE, waits a
// fixed number of cycles, then completes it against a 2**ADDR_W x DATA_W array.
module mem_responder #(
  parameter int WAIT_STATES = 1,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic              fetch,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] ir,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state_reg;
  logic [2:0]          cnt_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic                we_reg;
  logic                fetch_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [DATA_W-1:0]   mem [2**ADDR_W];

  logic                complete;
  logic [ADDR_W-1:0]   op_addr;
  logic                op_we;
  logic                op_fetch;
  logic [DATA_W-1:0]   op_wdata;

  // With no wait states the request completes on its sampling edge, so the
  // operands come straight from the bus instead of the latched copies.
  always_comb begin
    if (WAIT_STATES == 0) begin
      complete = (state_reg == IDLE) && req;
      op_addr  = address;
      op_we    = we;
      op_fetch = fetch;
      op_wdata = wdata;
    end else begin
      complete = (state_reg == WAIT) && (cnt_reg == 3'd0);
      op_addr  = addr_reg;
      op_we    = we_reg;
      op_fetch = fetch_reg;
      op_wdata = wdata_reg;
    end
  end

  // Memory has no reset; a request dropped by reset must not write.
  always_ff @(posedge clk) begin
    if (rst_n && complete && op_we)
      mem[op_addr] <= op_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 3'd0;
      addr_reg  <= '0;
      we_reg    <= 1'b0;
      fetch_reg <= 1'b0;
      wdata_reg <= '0;
      ack       <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      rdata     <= '0;
      ir        <= '0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req) begin
            addr_reg  <= address;
            we_reg    <= we;
            fetch_reg <= fetch;
            wdata_reg <= wdata;
            busy      <= 1'b1;
            if (WAIT_STATES == 0) begin
              state_reg <= RESP;
            end else begin
              state_reg <= WAIT;
              cnt_reg   <= 3'(WAIT_STATES - 1);
            end
          end
        end
        WAIT: begin
          if (cnt_reg == 3'd0)
            state_reg <= RESP;
          else
            cnt_reg <= cnt_reg - 3'd1;
        end
        RESP: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase

      if (complete) begin
        ack <= 1'b1;
        err <= op_fetch & op_we;
        // Illegal fetch+write still writes but never touches rdata or ir.
        if (!op_we) begin
          rdata <= mem[op_addr];
          if (op_fetch)
            ir <= mem[op_addr];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances (WAIT_STATES 1, 0, 3) share
// the bus inputs; only the instance under test is kept out of reset.
module tb_mem_responder;

  localparam int WS [3] = '{1, 0, 3};

  logic             clk = 1'b0;
  logic             req = 1'b0;
  logic             we = 1'b0;
  logic             fetch = 1'b0;
  logic [7:0]       address = 8'h00;
  logic [7:0]       wdata = 8'h00;
  logic [2:0]       rst_a = 3'b000;
  logic [2:0]       ack_a;
  logic [2:0]       busy_a;
  logic [2:0]       err_a;
  logic [2:0][7:0]  rdata_a;
  logic [2:0][7:0]  ir_a;

  int tests = 0;
  int failed = 0;

  logic [7:0] snap_rdata;
  logic [7:0] snap_ir;
  logic       snap_err;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    mem_responder #(.WAIT_STATES(WS[gi]), .ADDR_W(8), .DATA_W(8)) u_dut (
      .clk     (clk),
      .rst_n   (rst_a[gi]),
      .req     (req),
      .we      (we),
      .fetch   (fetch),
      .address (address),
      .wdata   (wdata),
      .ack     (ack_a[gi]),
      .rdata   (rdata_a[gi]),
      .ir      (ir_a[gi]),
      .busy    (busy_a[gi]),
      .err     (err_a[gi])
    );
  end

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic select(input int s);
    @(negedge clk);
    rst_a = 3'b000;
    rst_a[s] = 1'b1;
  endtask

  // One request on instance s; captures ack-cycle outputs into snap_*.
  task automatic xact(input int s, input logic w, input logic f,
                      input logic [7:0] a, input logic [7:0] d, input string tag);
    int n;
    @(negedge clk);
    we = w; fetch = f; address = a; wdata = d; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    check(32'(busy_a[s]), 32'd1, {tag, " busy"});
    n = 1;
    while (!ack_a[s] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(32'(n), 32'(WS[s] + 1), {tag, " latency"});
    snap_rdata = rdata_a[s];
    snap_ir    = ir_a[s];
    snap_err   = err_a[s];
    $display("[TB] %s: inst %0d we=%0d fetch=%0d addr=%02h wdata=%02h -> lat=%0d rdata=%02h ir=%02h err=%0d",
             tag, s, w, f, a, d, n, snap_rdata, snap_ir, snap_err);
    @(negedge clk);
    check(32'(ack_a[s]), 32'd0, {tag, " ack one cycle"});
    check(32'(busy_a[s]), 32'd0, {tag, " busy drop"});
  endtask

  initial begin
    // Reset then idle
    repeat (3) @(negedge clk);
    rst_a = 3'b111;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check(32'(ack_a), 32'd0, "idle ack");
      check(32'(busy_a), 32'd0, "idle busy");
      check(32'(err_a), 32'd0, "idle err");
      check(32'(rdata_a), 32'd0, "idle rdata");
      check(32'(ir_a), 32'd0, "idle ir");
    end
    $display("[TB] reset/idle: 10 idle cycles observed");

    // WAIT_STATES=1: write/read, fetch, illegal request
    select(0);
    xact(0, 1'b1, 1'b0, 8'h3C, 8'hA5, "wr 3C");
    check(32'(snap_err), 32'd0, "wr 3C err");
    check(32'(snap_rdata), 32'h00, "wr 3C rdata unchanged");
    xact(0, 1'b0, 1'b0, 8'h3C, 8'h00, "rd 3C");
    check(32'(snap_rdata), 32'hA5, "rd 3C rdata");
    check(32'(snap_ir), 32'h00, "rd 3C ir");
    xact(0, 1'b1, 1'b0, 8'h00, 8'h7E, "wr 00");
    xact(0, 1'b0, 1'b1, 8'h00, 8'h00, "fetch 00");
    check(32'(snap_rdata), 32'h7E, "fetch rdata");
    check(32'(snap_ir), 32'h7E, "fetch ir");
    xact(0, 1'b1, 1'b1, 8'hFF, 8'h55, "illegal FF");
    check(32'(snap_err), 32'd1, "illegal err");
    check(32'(snap_ir), 32'h7E, "illegal ir");
    check(32'(snap_rdata), 32'h7E, "illegal rdata");
    xact(0, 1'b0, 1'b0, 8'hFF, 8'h00, "rd FF");
    check(32'(snap_rdata), 32'h55, "rd FF rdata");
    check(32'(snap_ir), 32'h7E, "rd FF ir");
    check(32'(snap_err), 32'd0, "rd FF err");

    // WAIT_STATES=0: preload, then back-to-back reads with req held
    select(1);
    for (int i = 0; i < 4; i++)
      xact(1, 1'b1, 1'b0, 8'(i), 8'(8'h10 + i), "preload");
    @(negedge clk);
    we = 1'b0; fetch = 1'b0; address = 8'h00; req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      check(32'(ack_a[1]), 32'd1, "b2b ack high");
      check(32'(rdata_a[1]), 32'(8'h10 + i), "b2b rdata");
      $display("[TB] b2b read addr=%02h -> ack=%0d rdata=%02h", 8'(i), ack_a[1], rdata_a[1]);
      @(posedge clk);
      @(negedge clk);
      check(32'(ack_a[1]), 32'd0, "b2b ack low");
      address = 8'(i + 1);
    end
    req = 1'b0;

    // WAIT_STATES=3: reset while in WAIT drops the write
    select(2);
    xact(2, 1'b1, 1'b0, 8'h10, 8'h22, "wr 10");
    @(negedge clk);
    we = 1'b1; fetch = 1'b0; address = 8'h10; wdata = 8'h99; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    check(32'(busy_a[2]), 32'd1, "rst-mid busy");
    @(posedge clk);
    #1;
    rst_a[2] = 1'b0;
    #1;
    check(32'(busy_a[2]), 32'd0, "rst-mid busy cleared");
    check(32'(ack_a[2]), 32'd0, "rst-mid ack");
    @(negedge clk);
    rst_a[2] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check(32'(ack_a[2]), 32'd0, "rst-mid no ack");
    end
    $display("[TB] reset mid-operation: write 99 to 10 dropped");
    xact(2, 1'b0, 1'b0, 8'h10, 8'h00, "rd 10");
    check(32'(snap_rdata), 32'h22, "rd 10 rdata");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
